// File: rtl/riscv_aes_seq_ctrl.sv
// riscv_aes_seq_ctrl: snapshots AES operands, drives the core over req/ack with a timeout,
// and writes the 128-bit result back as four words.
module riscv_aes_seq_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 3,
    parameter int TIMEOUT_W      = 10,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic                    abort_i,
    input  logic [DATA_WIDTH-1:0]   op_a_i,
    input  logic [DATA_WIDTH-1:0]   op_b_i,
    input  logic [DATA_WIDTH-1:0]   op_c_i,
    input  logic [DATA_WIDTH-1:0]   op_d_i,
    output logic                    core_req_o,
    output logic [4*DATA_WIDTH-1:0] core_din_o,
    input  logic                    core_ack_i,
    input  logic                    core_valid_i,
    input  logic [4*DATA_WIDTH-1:0] core_dout_i,
    output logic                    res_wen_o,
    output logic [ADDR_WIDTH-1:0]   res_waddr_o,
    output logic [DATA_WIDTH-1:0]   res_wdata_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, WB, DONE, ERR} state_t;
    state_t state, state_nx;
    logic [4*DATA_WIDTH-1:0] din, res;
    logic [TIMEOUT_W-1:0] cnt;
    logic [1:0] idx, sel;
    logic accept, expired;
    assign accept  = (state == IDLE || state == ERR) && start_i && !abort_i;
    assign expired = cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1);
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, ERR: state_nx = start_i ? REQ : state;
            REQ:       state_nx = expired ? ERR : core_ack_i ? WAIT : REQ;
            WAIT:      state_nx = core_valid_i ? WB : expired ? ERR : WAIT;
            WB:        state_nx = idx == 2'd3 ? DONE : WB;
            DONE:      state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
        if (abort_i) state_nx = IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            din   <= '0;
            res   <= '0;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                din <= {op_a_i, op_b_i, op_c_i, op_d_i};
                cnt <= '0;
            end else if ((state == REQ || state == WAIT) && cnt != '1) begin
                cnt <= cnt + 1'b1;
            end
            if (state == WAIT && core_valid_i) begin
                res <= core_dout_i;
                idx <= '0;
            end else if (state == WB) begin
                idx <= idx + 1'b1;
            end
        end
    end
    // word 0 is the most significant quarter of the result block
    assign sel         = ~idx;
    assign core_req_o  = state == REQ;
    assign core_din_o  = din;
    assign res_wen_o   = state == WB;
    assign res_waddr_o = ADDR_WIDTH'(idx);
    assign res_wdata_o = res[sel*DATA_WIDTH +: DATA_WIDTH];
    assign busy_o      = state == REQ || state == WAIT || state == WB;
    assign done_o      = state == DONE;
    assign err_o       = state == ERR;
endmodule

// File: tb/tb_riscv_aes_seq_ctrl.sv
// tb_riscv_aes_seq_ctrl: directed bench with a transaction-level reference model and
// per-cycle output comparison.
module tb_riscv_aes_seq_ctrl;
    localparam int TO = 20;
    logic clk = 0, rst_n = 0;
    logic start_i = 0, abort_i = 0, core_ack_i = 0, core_valid_i = 0;
    logic [31:0] op_a = 0, op_b = 0, op_c = 0, op_d = 0;
    logic [127:0] core_dout_i = 0, core_din_o;
    logic core_req_o, res_wen_o, busy_o, done_o, err_o;
    logic [2:0] res_waddr_o;
    logic [31:0] res_wdata_o;
    int errors = 0, checks = 0, done_n = 0;
    int wr_a[$];
    logic [31:0] wr_d[$];

    riscv_aes_seq_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .TIMEOUT_W(10), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
        .op_a_i(op_a), .op_b_i(op_b), .op_c_i(op_c), .op_d_i(op_d),
        .core_req_o(core_req_o), .core_din_o(core_din_o), .core_ack_i(core_ack_i),
        .core_valid_i(core_valid_i), .core_dout_i(core_dout_i),
        .res_wen_o(res_wen_o), .res_waddr_o(res_waddr_o), .res_wdata_o(res_wdata_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: phase flags plus a write index, advanced once per clock edge.
    bit m_req = 0, m_wait = 0, m_done = 0, m_err = 0;
    int m_wb = -1, m_cnt = 0;
    logic [127:0] m_din = 0, m_res = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_req = 0; m_wait = 0; m_done = 0; m_err = 0; m_wb = -1; m_cnt = 0;
            m_din = 0; m_res = 0;
        end else if (abort_i) begin
            m_req = 0; m_wait = 0; m_done = 0; m_err = 0; m_wb = -1;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_wb >= 0) begin
            if (m_wb == 3) begin m_wb = -1; m_done = 1; end
            else m_wb++;
        end else if (m_req || m_wait) begin
            if (m_wait && core_valid_i) begin m_wait = 0; m_wb = 0; m_res = core_dout_i; end
            else if (m_cnt == TO - 1) begin m_req = 0; m_wait = 0; m_err = 1; end
            else if (m_req && core_ack_i) begin m_req = 0; m_wait = 1; end
            m_cnt++;
        end else if (start_i) begin
            m_req = 1; m_err = 0; m_cnt = 0; m_din = {op_a, op_b, op_c, op_d};
        end
    end

    always @(negedge clk) begin
        chk("req", core_req_o, m_req);
        chk("busy", busy_o, m_req || m_wait || m_wb >= 0);
        chk("wen", res_wen_o, m_wb >= 0);
        chk("done", done_o, m_done);
        chk("err", err_o, m_err);
        chk("din", core_din_o, m_din);
        if (m_wb >= 0) begin
            chk("waddr", res_waddr_o, m_wb);
            chk("wdata", res_wdata_o, m_res[127-32*m_wb -: 32]);
        end
        if (rst_n && res_wen_o) begin wr_a.push_back(int'(res_waddr_o)); wr_d.push_back(res_wdata_o); end
        if (rst_n && done_o) done_n++;
    end

    task automatic tick(); @(posedge clk); #1; endtask
    task automatic clear_log(); wr_a.delete(); wr_d.delete(); done_n = 0; endtask
    task automatic do_start(input logic [127:0] ops);
        {op_a, op_b, op_c, op_d} = ops; start_i = 1; tick(); start_i = 0;
    endtask
    task automatic ack_after(input int n);
        repeat (n) tick(); core_ack_i = 1; tick(); core_ack_i = 0;
    endtask
    task automatic valid_after(input int n, input logic [127:0] r);
        repeat (n) tick(); core_dout_i = r; core_valid_i = 1; tick(); core_valid_i = 0;
    endtask
    task automatic wait_done();
        bit ok = 0;
        for (int i = 0; i < 30 && !ok; i++) begin tick(); ok = done_o; end
        chk("done_seen", ok, 1);
        tick();
    endtask
    task automatic check_run(input string name, input logic [127:0] r, input int nwr, input int ndone);
        chk({name, "_nwr"}, wr_d.size(), nwr);
        for (int i = 0; i < nwr && i < wr_d.size(); i++) begin
            chk({name, "_addr"}, wr_a[i], i);
            chk({name, "_data"}, wr_d[i], r[127-32*i -: 32]);
        end
        chk({name, "_ndone"}, done_n, ndone);
    endtask

    localparam logic [127:0] OPS = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] RES = 128'h69C4E0D8_6A7B0430_D8CDB780_70B4C55A;
    logic [127:0] r;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outs", {core_req_o, res_wen_o, busy_o, done_o, err_o}, 0);
        chk("rst_din", core_din_o, 0);
        chk("rst_w", {res_waddr_o, res_wdata_o}, 0);
        rst_n = 1;
        tick();
        // nominal run with hand-computed write data
        clear_log();
        do_start(OPS);
        chk("nom_din", core_din_o, 128'h00112233_44556677_8899AABB_CCDDEEFF);
        chk("nom_req", core_req_o, 1);
        ack_after(2);
        chk("nom_req_low", core_req_o, 0);
        valid_after(7, RES);
        wait_done();
        chk("nom_w0", wr_d.size() > 0 ? wr_d[0] : 0, 32'h69C4E0D8);
        chk("nom_w3", wr_d.size() > 3 ? wr_d[3] : 0, 32'h70B4C55A);
        check_run("nom", RES, 4, 1);
        chk("nom_err", err_o, 0);
        // start during WAIT and operand change are ignored
        clear_log();
        do_start(OPS);
        ack_after(0);
        tick();
        start_i = 1; {op_a, op_b, op_c, op_d} = '1;
        tick();
        start_i = 0;
        chk("busy_din", core_din_o, 128'h00112233_44556677_8899AABB_CCDDEEFF);
        valid_after(1, ~RES);
        wait_done();
        check_run("busy", ~RES, 4, 1);
        // timeout: err exactly TO edges after the start edge
        clear_log();
        do_start(OPS);
        ack_after(0);
        repeat (TO - 2) tick();
        chk("to_early", err_o, 0);
        tick();
        chk("to_err", err_o, 1);
        chk("to_busy", busy_o, 0);
        repeat (3) tick();
        check_run("to", RES, 0, 0);
        do_start(RES);
        chk("to_clr", err_o, 0);
        chk("to_restart", busy_o, 1);
        ack_after(1);
        valid_after(2, OPS);
        wait_done();
        check_run("to_rerun", OPS, 4, 1);
        // abort in WAIT, then a late valid is ignored
        clear_log();
        do_start(OPS);
        ack_after(0);
        tick();
        abort_i = 1; tick(); abort_i = 0;
        chk("ab_wait_busy", busy_o, 0);
        valid_after(0, RES);
        repeat (6) tick();
        check_run("ab_wait", RES, 0, 0);
        // abort in the second write cycle
        clear_log();
        do_start(OPS);
        ack_after(0);
        valid_after(0, RES);
        tick();
        abort_i = 1; tick(); abort_i = 0;
        chk("ab_wb_wen", res_wen_o, 0);
        repeat (5) tick();
        check_run("ab_wb", RES, 2, 0);
        // abort beats start
        clear_log();
        start_i = 1; abort_i = 1; tick(); start_i = 0; abort_i = 0;
        chk("ab_st", {busy_o, core_req_o}, 0);
        repeat (3) tick();
        check_run("ab_st", RES, 0, 0);
        // reset during the third write
        clear_log();
        do_start(OPS);
        ack_after(0);
        valid_after(0, RES);
        repeat (2) tick();
        rst_n = 0;
        #1;
        chk("mid_rst_outs", {core_req_o, res_wen_o, busy_o, done_o, err_o}, 0);
        chk("mid_rst_w", {core_din_o, res_waddr_o, res_wdata_o}, 0);
        tick();
        rst_n = 1;
        repeat (3) tick();
        check_run("mid_rst", RES, 2, 0);
        clear_log();
        do_start(OPS);
        ack_after(0);
        valid_after(0, RES);
        wait_done();
        check_run("post_rst", RES, 4, 1);
        // back-to-back runs with random handshake delays
        for (int k = 0; k < 8; k++) begin
            clear_log();
            r = {$urandom, $urandom, $urandom, $urandom};
            do_start({$urandom, $urandom, $urandom, $urandom});
            ack_after($urandom_range(0, 3));
            valid_after($urandom_range(0, 5), r);
            wait_done();
            check_run("b2b", r, 4, 1);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/riscv_aes_seq_ctrl.md
# riscv_aes_seq_ctrl

Sequencer between the RISC-V AES operand register file and the 128-bit AES core. On a start pulse it snapshots the four 32-bit operand words, hands them to the core over a req/ack handshake, and waits for the result with a timeout. It then writes the 128-bit result back as four 32-bit words into the result register file and reports done or error. It is the only master of the core and of the result write port.

## Interface
- DATA_WIDTH, 32, width of one operand/result word
- ADDR_WIDTH, 3, result write-address width
- TIMEOUT_W, 10, timeout counter width
- TIMEOUT_CYCLES, 1000, maximum cycles spent in REQ+WAIT before error; legal range 2..2**TIMEOUT_W-1
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start_i  in  1  start pulse from the operand register file's aes_start
- abort_i  in  1  synchronous abort; returns to IDLE and clears error
- op_a_i, op_b_i, op_c_i, op_d_i  in  DATA_WIDTH each  operand words 0..3
- core_req_o  out  1  operand valid to core
- core_din_o  out  4*DATA_WIDTH  operand block {a,b,c,d}; a in MSBs
- core_ack_i  in  1  core accepted operand
- core_valid_i  in  1  result valid, single-cycle pulse
- core_dout_i  in  4*DATA_WIDTH  result block
- res_wen_o  out  1  result write enable
- res_waddr_o  out  ADDR_WIDTH  result word address
- res_wdata_o  out  DATA_WIDTH  result word
- busy_o  out  1  operation in progress
- done_o  out  1  single-cycle completion pulse
- err_o  out  1  timeout flag, held until cleared

## Operation
- States: IDLE, REQ, WAIT, WB, DONE, ERR.
- IDLE: start_i=1 -> latch {op_a..op_d} into the din register, clear timeout counter, go to REQ.
- REQ: core_req_o=1 and core_din_o held stable. core_ack_i=1 -> WAIT with counter not cleared.
- WAIT: core_valid_i=1 -> latch core_dout_i into the result register, clear word index, go to WB. core_valid_i outside WAIT is ignored.
- WB: res_wen_o=1 for 4 consecutive cycles. res_waddr_o=index 0..3. res_wdata_o = result[127:96], [95:64], [63:32], [31:0] in that order. After index 3 -> DONE.
- DONE: done_o=1 for one cycle, then IDLE.
- Timeout: counter increments every cycle in REQ and WAIT. If the counter reaches TIMEOUT_CYCLES-1 without exiting WAIT -> ERR. Counter saturates and never wraps.
- ERR: err_o=1, busy_o=0. start_i clears err_o and behaves exactly as in IDLE. abort_i -> IDLE.
- busy_o=1 in REQ, WAIT and WB only.
- start_i in any state other than IDLE or ERR is ignored and is not queued.
- abort_i in any state -> IDLE next cycle. It drops core_req_o and res_wen_o immediately (registered) and causes no partial write. A WB already in progress stops after the current cycle's write.
- abort_i and start_i in the same cycle: abort wins and the start is dropped.
- Latched operands are immune to operand-register changes after the start cycle.

## Timing
- All outputs are registered or decoded from registered state. There are no combinational paths from inputs to outputs.
- Reset values: state=IDLE, core_req_o=0, core_din_o=0, res_wen_o=0, res_waddr_o=0, res_wdata_o=0, busy_o=0, done_o=0, err_o=0, counter=0.
- Reset asserted mid-operation returns the block to these values immediately. No write and no done pulse is issued.
- Start sampled at edge E0: core_req_o and busy_o are high from E0 onward.
- Ack sampled at edge E1 (req&ack): core_req_o is low after E1.
- Valid sampled at edge E2: writes occur at edges E2+1..E2+4. done_o is high between E2+4 and E2+5. busy_o is low after E2+4.
- Best case from start to done is 6 cycles (ack in the first REQ cycle, valid in the first WAIT cycle).
- Timeout: err_o rises exactly TIMEOUT_CYCLES edges after E0 when no valid result arrives.
- A new start is accepted at the earliest in the cycle after done_o (IDLE).

## Test plan
- Nominal: ops a..d = 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF; core acks after 2 cycles and returns 0x69C4E0D86A7B0430D8CDB78070B4C55A after 10 cycles -> core_din_o matches the operand block; writes addr0=0x69C4E0D8, addr1=0x6A7B0430, addr2=0xD8CDB780, addr3=0x70B4C55A on consecutive cycles; one done_o pulse; err_o=0.
- Start while busy: a second start_i during WAIT -> ignored; exactly 4 writes and 1 done. Operand change after start -> core_din_o unchanged.
- Timeout: TIMEOUT_CYCLES=20, core never asserts valid -> err_o=1 twenty edges after start, busy_o=0, no writes. A following start clears err_o and completes normally.
- Abort: abort_i in WAIT -> IDLE next cycle, no writes, no done. abort_i in the 2nd WB cycle -> only addr0 and addr1 are written. abort_i together with start_i in IDLE -> stays IDLE.
- Reset mid-WB: rst_n low during the 3rd write -> all outputs return to reset values immediately. After release, a start completes a clean full run.
- Back-to-back: start issued in the cycle after done_o, 8 iterations with random ack/valid delays -> every result written in order, each run exactly 4 writes and 1 done.
